// File: rtl/sim_top.sv
// rtl/sim_top.sv - DS18B20 presence detector: periodic 1-Wire reset pulse, presence sample, RGB status LED.
module sim_top #(
  parameter int RESET_LOW_CYCLES     = 480,
  parameter int RELEASE_CHECK_CYCLES = 2,
  parameter int SAMPLE_CYCLES        = 70,
  parameter int WINDOW_CYCLES        = 480,
  parameter int PERIOD_CYCLES        = 21000
) (
  input  logic clk,
  input  logic rst,
  output logic O_LED_R,
  output logic O_LED_G,
  output logic O_LED_B,
  input  logic I_ONE_WIRE,
  output logic O_ONE_WIRE
);

  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] P_REL  = PW'(RESET_LOW_CYCLES);
  localparam logic [PW-1:0] P_CHK  = PW'(RESET_LOW_CYCLES + RELEASE_CHECK_CYCLES);
  localparam logic [PW-1:0] P_SMP  = PW'(RESET_LOW_CYCLES + SAMPLE_CYCLES);
  localparam logic [PW-1:0] P_LAT  = PW'(RESET_LOW_CYCLES + WINDOW_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_LOW,
    S_RELEASE_CHECK,
    S_PRESENCE_SAMPLE,
    S_RECOVERY
  } state_t;

  state_t        state;
  logic [PW-1:0] p;
  logic [PW-1:0] p_next;
  logic          started;
  logic          sync1;
  logic          bus_s;
  logic          fault;
  logic          present;

  // The first edge after reset holds p at 0 so the run begins on that edge.
  always_comb begin
    p_next = '0;
    if (started && p != P_LAST)
      p_next = p + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b1;
      bus_s      <= 1'b1;
      p          <= '0;
      started    <= 1'b0;
      state      <= S_IDLE;
      fault      <= 1'b0;
      present    <= 1'b0;
      O_ONE_WIRE <= 1'b1;
      O_LED_R    <= 1'b1;
      O_LED_G    <= 1'b1;
      O_LED_B    <= 1'b1;
    end else begin
      sync1   <= I_ONE_WIRE;
      bus_s   <= sync1;
      started <= 1'b1;
      p       <= p_next;
      if (p_next == '0) begin
        state      <= S_RESET_LOW;
        fault      <= 1'b0;
        present    <= 1'b0;
        O_ONE_WIRE <= 1'b0;
        O_LED_B    <= 1'b0;
      end else begin
        case (state)
          S_RESET_LOW: if (p_next == P_REL) begin
            state      <= S_RELEASE_CHECK;
            O_ONE_WIRE <= 1'b1;
            O_LED_B    <= 1'b1;
          end
          S_RELEASE_CHECK: if (p_next == P_CHK) begin
            state <= S_PRESENCE_SAMPLE;
            if (!bus_s) begin
              fault   <= 1'b1;
              O_LED_B <= 1'b0;
            end
          end
          S_PRESENCE_SAMPLE: if (p_next == P_SMP) begin
            state   <= S_RECOVERY;
            present <= !bus_s;
          end
          S_RECOVERY: if (p_next == P_LAT) begin
            state <= S_IDLE;
            if (fault) begin
              O_LED_R <= 1'b0;
              O_LED_G <= 1'b1;
              O_LED_B <= 1'b0;
            end else if (present) begin
              O_LED_R <= 1'b1;
              O_LED_G <= 1'b0;
              O_LED_B <= 1'b1;
            end else begin
              O_LED_R <= 1'b0;
              O_LED_G <= 1'b1;
              O_LED_B <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sim_top.sv
// tb/tb_sim_top.sv - randomized self-checking bench for sim_top against a per-run presence model.
module tb_sim_top;

  localparam int R   = 480;
  localparam int W   = 480;
  localparam int PER = 1500;

  logic clk = 1'b0;
  logic rst;
  logic led_r, led_g, led_b;
  logic ow_in, ow_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_x      = 0;
  bit have_prev = 0;
  logic [2:0] prev_leds;

  always #5 clk = ~clk;

  sim_top #(.PERIOD_CYCLES(PER)) dut (
    .clk(clk),
    .rst(rst),
    .O_LED_R(led_r),
    .O_LED_G(led_g),
    .O_LED_B(led_b),
    .I_ONE_WIRE(ow_in),
    .O_ONE_WIRE(ow_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {R,G,B} after the latch point: fault wins, then presence, else absent.
  function automatic logic [2:0] expect_leds(input bit flt, input bit pres);
    if (flt)  return 3'b010;
    if (pres) return 3'b101;
    return 3'b011;
  endfunction

  task automatic run_once(input int pat, input bit abort);
    int lo_s, lo_e, low_cnt;
    logic [2:0] exp;
    case (pat)
      1: begin lo_s = R + 10 + int'($urandom_range(0, 40)); lo_e = R + 90 + int'($urandom_range(0, 200)); end
      2: begin lo_s = R + 90 + int'($urandom_range(0, 50)); lo_e = R + 150 + int'($urandom_range(0, 200)); end
      3: begin lo_s = R + 10; lo_e = R + 40 + int'($urandom_range(0, 15)); end
      4: begin lo_s = 0; lo_e = PER + 1; end
      5: begin lo_s = 0; lo_e = R + 20 + int'($urandom_range(0, 20)); end
      default: begin lo_s = -1; lo_e = -1; end
    endcase
    exp = expect_leds((R + 2 >= lo_s) && (R + 2 < lo_e), (R + 70 >= lo_s) && (R + 70 < lo_e));
    low_cnt = 0;
    for (int o = 0; o < PER; o++) begin
      @(posedge clk);
      #1;
      if ($isunknown({led_r, led_g, led_b, ow_out})) n_x++;
      if (ow_out == 1'b0) low_cnt++;
      ow_in = !((o >= lo_s) && (o < lo_e));
      if (o == 0) check("ow_low_start", ow_out, 0);
      if (o == 200) begin
        check("rst_low_b", led_b, 0);
        if (have_prev) check("held_rg", {led_r, led_g}, prev_leds[2:1]);
        else           check("pre_latch_rg", {led_r, led_g}, 2'b11);
        if (abort) begin
          rst = 1'b1;
          #1;
          check("abort_ow", ow_out, 1);
          check("abort_leds", {led_r, led_g, led_b}, 3'b111);
          repeat (3) @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          ow_in = 1'b1;
          have_prev = 0;
          return;
        end
      end
      if (o == R + 5) check("ow_released", ow_out, 1);
      if (o == R + W + 5) check("latch_leds", {led_r, led_g, led_b}, exp);
      if (o == PER - 1) check("end_leds", {led_r, led_g, led_b}, exp);
    end
    check("ow_low_len", low_cnt, R);
    have_prev = 1;
    prev_leds = exp;
  endtask

  initial begin
    int pats[6];
    pats = '{1, 1, 0, 4, 0, 5};
    rst = 1'b1;
    ow_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("reset_ow", ow_out, 1);
    check("reset_leds", {led_r, led_g, led_b}, 3'b111);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k < 6) run_once(pats[k], 1'b0);
      else       run_once(int'($urandom_range(0, 5)), k == 7);
    end
    check("no_x", n_x, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
